// File: rtl/lfsr_engine_if.sv
// Control and observation bundle for lfsr_engine: step/load controls in, state and period out.
interface lfsr_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic              en;
    logic [1:0]        mode;
    logic              din;
    logic              load;
    logic [WIDTH-1:0]  pdata;
    logic [WIDTH-1:0]  qdata;
    logic              dout;
    logic              lockup;
    logic              period_valid;
    logic [CNT_W-1:0]  period;

    // Driver side: issues controls, observes state.
    modport master (
        output en, mode, din, load, pdata,
        input  qdata, dout, lockup, period_valid, period
    );

    // Engine side.
    modport slave (
        input  en, mode, din, load, pdata,
        output qdata, dout, lockup, period_valid, period
    );
endinterface

// File: rtl/lfsr_engine.sv
// Galois right-shift LFSR with free-run, scrambler and signature modes,
// zero-state recovery in free-run, and cycle-length measurement.
module lfsr_engine #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB3),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
    parameter int unsigned      CNT_W = 16
) (
    input logic          clk,
    input logic          arst,
    lfsr_engine_if.slave bus
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_SCRM = 2'b10;
    localparam logic [1:0] MODE_SIGN = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] snap_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;
    logic             pvalid_r;
    logic             lockup_r;

    logic             fb;
    logic             ib;
    logic             step;
    logic             recover;
    logic             match;
    logic [WIDTH-1:0] next_q;
    logic [CNT_W-1:0] cnt_inc;

    // Feedback/input bit selection, next state, and step qualifiers.
    always_comb begin
        fb = q_r[0];
        ib = 1'b0;
        case (bus.mode)
            MODE_SCRM: ib = bus.din;
            MODE_SIGN: fb = q_r[0] ^ bus.din;
            default:   ;
        endcase
        next_q  = {ib, q_r[WIDTH-1:1]} ^ (TAPS & {WIDTH{fb}});
        step    = ~bus.load & bus.en & (bus.mode != MODE_HOLD);
        recover = (bus.mode == MODE_FREE) && (q_r == '0);
        match   = (next_q == snap_r);
        cnt_inc = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    end

    // State, snapshot, step counter and period registers; load beats step.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            q_r      <= SEED;
            snap_r   <= SEED;
            cnt_r    <= '0;
            period_r <= '0;
            pvalid_r <= 1'b0;
            lockup_r <= 1'b0;
        end else begin
            lockup_r <= 1'b0;
            if (bus.load) begin
                q_r      <= bus.pdata;
                snap_r   <= bus.pdata;
                cnt_r    <= '0;
                pvalid_r <= 1'b0;
            end else if (step) begin
                if (recover) begin
                    q_r      <= SEED;
                    snap_r   <= SEED;
                    cnt_r    <= '0;
                    lockup_r <= 1'b1;
                end else begin
                    q_r <= next_q;
                    if (match) begin
                        period_r <= cnt_inc;
                        pvalid_r <= 1'b1;
                        cnt_r    <= '0;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
            end
        end
    end

    assign bus.qdata        = q_r;
    assign bus.dout         = q_r[0];
    assign bus.lockup       = lockup_r;
    assign bus.period_valid = pvalid_r;
    assign bus.period       = period_r;

    // Mode names kept for readability of the case above; hold is the default arm.
    logic unused_mode_names;
    assign unused_mode_names = ^{MODE_HOLD, MODE_FREE};

endmodule

// File: tb/tb_lfsr_engine.sv
// Randomised and directed checks of lfsr_engine against a step-count reference model.
module tb_lfsr_engine;

    logic clk;
    logic arst;

    lfsr_engine_if #(.WIDTH(8), .CNT_W(16)) b8 ();
    lfsr_engine_if #(.WIDTH(3), .CNT_W(16)) b3 ();
    lfsr_engine_if #(.WIDTH(8), .CNT_W(4))  b4 ();

    lfsr_engine #(.WIDTH(8), .TAPS(8'hB3), .SEED(8'h01), .CNT_W(16))
        dut8 (.clk(clk), .arst(arst), .bus(b8.slave));
    lfsr_engine #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b001), .CNT_W(16))
        dut3 (.clk(clk), .arst(arst), .bus(b3.slave));
    lfsr_engine #(.WIDTH(8), .TAPS(8'hB3), .SEED(8'h01), .CNT_W(4))
        dut4 (.clk(clk), .arst(arst), .bus(b4.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: state as an integer, period from a plain step count.
    int unsigned c_w, c_taps, c_seed, c_max;
    int unsigned m_q, m_snap, m_per;
    int          m_n;
    bit          m_pv, m_lock;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int unsigned galois(input int unsigned q, input int unsigned w,
                                           input int unsigned taps, input bit fb, input bit ib);
        int unsigned r;
        r = q >> 1;
        if (ib) r = r + (32'd1 << (w - 1));
        if (fb) r = r ^ taps;
        return r;
    endfunction

    task automatic set_cfg(input int unsigned w, input int unsigned taps,
                           input int unsigned seed, input int unsigned cmax);
        c_w = w; c_taps = taps; c_seed = seed; c_max = cmax;
    endtask

    task automatic mdl_reset();
        m_q = c_seed; m_snap = c_seed; m_n = 0; m_per = 0; m_pv = 0; m_lock = 0;
    endtask

    task automatic mdl_cycle(input bit ld, input bit e, input int md, input bit d, input int unsigned pd);
        bit fb, ib;
        m_lock = 0;
        if (ld) begin
            m_q = pd; m_snap = pd; m_n = 0; m_pv = 0;
        end else if (e && md != 0) begin
            if (md == 1 && m_q == 0) begin
                m_q = c_seed; m_snap = c_seed; m_n = 0; m_lock = 1;
            end else begin
                fb = m_q[0] ^ ((md == 3) ? d : 1'b0);
                ib = (md == 2) ? d : 1'b0;
                m_q = galois(m_q, c_w, c_taps, fb, ib);
                m_n++;
                if (m_q == m_snap) begin
                    m_per = (m_n > int'(c_max)) ? c_max : int'(m_n);
                    m_pv = 1;
                    m_n = 0;
                end
            end
        end
    endtask

    task automatic idle_all();
        b8.load = 0; b8.en = 0; b8.mode = 2'b00; b8.din = 0; b8.pdata = '0;
        b3.load = 0; b3.en = 0; b3.mode = 2'b00; b3.din = 0; b3.pdata = '0;
        b4.load = 0; b4.en = 0; b4.mode = 2'b00; b4.din = 0; b4.pdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b0;
        idle_all();
        mdl_reset();
        @(negedge clk);
        arst = 1'b1;
    endtask

    task automatic cyc8(input bit ld, input bit e, input logic [1:0] md, input bit d, input logic [7:0] pd);
        @(negedge clk);
        b8.load = ld; b8.en = e; b8.mode = md; b8.din = d; b8.pdata = pd;
        @(posedge clk);
        mdl_cycle(ld, e, int'(md), d, int'(pd));
        #1;
    endtask

    task automatic cyc3(input bit e, input logic [1:0] md);
        @(negedge clk);
        b3.load = 0; b3.en = e; b3.mode = md; b3.din = 0;
        @(posedge clk);
        mdl_cycle(0, e, int'(md), 0, 0);
        #1;
    endtask

    task automatic cyc4(input bit e, input logic [1:0] md);
        @(negedge clk);
        b4.load = 0; b4.en = e; b4.mode = md; b4.din = 0;
        @(posedge clk);
        mdl_cycle(0, e, int'(md), 0, 0);
        #1;
    endtask

    task automatic test_reset();
        set_cfg(8, 32'hB3, 1, 16'hFFFF);
        arst = 1'b1;
        idle_all();
        #1 arst = 1'b0;
        #1;
        checks++;
        if (b8.qdata !== 8'h01 || b8.dout !== 1'b1 || b8.lockup !== 1'b0 ||
            b8.period_valid !== 1'b0 || b8.period !== 16'h0) begin
            errors++;
            $display("FAIL reset8: q=%h dout=%b lk=%b pv=%b per=%h required q=01 dout=1 lk=0 pv=0 per=0000",
                     b8.qdata, b8.dout, b8.lockup, b8.period_valid, b8.period);
        end
        checks++;
        if (b3.qdata !== 3'b001 || b4.qdata !== 8'h01 || b4.period !== 4'h0) begin
            errors++;
            $display("FAIL reset_small: q3=%b q4=%h per4=%h required q3=001 q4=01 per4=0",
                     b3.qdata, b4.qdata, b4.period);
        end
        @(negedge clk);
        arst = 1'b1;
        mdl_reset();
    endtask

    task automatic test_directed();
        bit done = 0;
        set_cfg(8, 32'hB3, 1, 16'hFFFF);
        do_reset();
        cyc8(0, 1, 2'b01, 0, 8'h00);
        checks++;
        if (b8.qdata !== 8'hB3 || b8.dout !== 1'b1) begin
            errors++; $display("FAIL free_step1: q=%h dout=%b required q=b3 dout=1", b8.qdata, b8.dout);
        end
        cyc8(0, 1, 2'b01, 0, 8'h00);
        checks++;
        if (b8.qdata !== 8'hEA || b8.dout !== 1'b0) begin
            errors++; $display("FAIL free_step2: q=%h dout=%b required q=ea dout=0", b8.qdata, b8.dout);
        end
        cyc8(1, 0, 2'b00, 0, 8'h00);
        cyc8(0, 1, 2'b10, 1, 8'h00);
        checks++;
        if (b8.qdata !== 8'h80 || b8.lockup !== 1'b0) begin
            errors++; $display("FAIL scramble_zero: q=%h lk=%b required q=80 lk=0", b8.qdata, b8.lockup);
        end
        cyc8(1, 0, 2'b00, 0, 8'h00);
        cyc8(0, 1, 2'b11, 1, 8'h00);
        checks++;
        if (b8.qdata !== 8'hB3 || b8.lockup !== 1'b0) begin
            errors++; $display("FAIL signature_zero: q=%h lk=%b required q=b3 lk=0", b8.qdata, b8.lockup);
        end
        cyc8(1, 0, 2'b00, 0, 8'h00);
        cyc8(0, 1, 2'b01, 0, 8'h00);
        checks++;
        if (b8.qdata !== 8'h01 || b8.lockup !== 1'b1) begin
            errors++; $display("FAIL lockup_set: q=%h lk=%b required q=01 lk=1", b8.qdata, b8.lockup);
        end
        cyc8(0, 0, 2'b01, 0, 8'h00);
        checks++;
        if (b8.qdata !== 8'h01 || b8.lockup !== 1'b0) begin
            errors++; $display("FAIL lockup_pulse: q=%h lk=%b required q=01 lk=0", b8.qdata, b8.lockup);
        end
        // Period measured after recovery depends on the counter restarting.
        for (int i = 0; i < 400 && !done; i++) begin
            cyc8(0, 1, 2'b01, 0, 8'h00);
            if (m_pv) done = 1;
        end
        checks++;
        if (!done || b8.period_valid !== 1'b1 || b8.period !== 16'(m_per)) begin
            errors++;
            $display("FAIL period_after_lockup: done=%b pv=%b per=%0d required pv=1 per=%0d",
                     done, b8.period_valid, b8.period, m_per);
        end
    endtask

    task automatic test_period3();
        logic [2:0] exp3 [7];
        exp3 = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
        set_cfg(3, 32'h6, 1, 16'hFFFF);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc3(1, 2'b01);
            checks++;
            if (b3.qdata !== exp3[i] || b3.period_valid !== (i == 6)) begin
                errors++;
                $display("FAIL seq3 step %0d: q=%b pv=%b required q=%b pv=%b",
                         i + 1, b3.qdata, b3.period_valid, exp3[i], (i == 6));
            end
        end
        checks++;
        if (b3.period !== 16'd7) begin
            errors++; $display("FAIL period3: per=%0d required 7", b3.period);
        end
    endtask

    task automatic test_random();
        bit ld, e, d;
        logic [1:0] md;
        logic [7:0] pd;
        set_cfg(8, 32'hB3, 1, 16'hFFFF);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 4) != 0);
            md = 2'($urandom_range(0, 3));
            d  = 1'($urandom_range(0, 1));
            pd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cyc8(ld, e, md, d, pd);
            checks++;
            if (b8.qdata !== 8'(m_q) || b8.dout !== m_q[0] || b8.lockup !== m_lock ||
                b8.period_valid !== m_pv || b8.period !== 16'(m_per)) begin
                errors++;
                $display("FAIL random cyc %0d: q=%h dout=%b lk=%b pv=%b per=%0d required q=%h lk=%b pv=%b per=%0d",
                         i, b8.qdata, b8.dout, b8.lockup, b8.period_valid, b8.period,
                         8'(m_q), m_lock, m_pv, m_per);
            end
        end
    endtask

    task automatic test_en_toggle();
        bit done = 0;
        bit e;
        set_cfg(8, 32'hB3, 1, 16'hFFFF);
        do_reset();
        for (int i = 0; i < 1500 && !done; i++) begin
            e = ($urandom_range(0, 9) < 7);
            cyc8(0, e, 2'b01, 0, 8'h00);
            checks++;
            if (b8.qdata !== 8'(m_q) || b8.period_valid !== m_pv) begin
                errors++;
                $display("FAIL en_toggle cyc %0d: q=%h pv=%b required q=%h pv=%b",
                         i, b8.qdata, b8.period_valid, 8'(m_q), m_pv);
            end
            if (m_pv) done = 1;
        end
        checks++;
        if (!done || b8.period_valid !== 1'b1 || b8.period !== 16'(m_per)) begin
            errors++;
            $display("FAIL en_toggle_period: done=%b pv=%b per=%0d required pv=1 per=%0d",
                     done, b8.period_valid, b8.period, m_per);
        end
    endtask

    task automatic test_load_priority();
        cyc8(1, 1, 2'b01, 0, 8'h5A);
        checks++;
        if (b8.qdata !== 8'h5A || b8.period_valid !== 1'b0 || b8.period !== 16'(m_per) || m_per == 0) begin
            errors++;
            $display("FAIL load_priority: q=%h pv=%b per=%0d required q=5a pv=0 per=%0d (nonzero)",
                     b8.qdata, b8.period_valid, b8.period, m_per);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc8(0, 1, 2'b01, 0, 8'h00);
        #2;
        b8.load = 1'b1; b8.pdata = 8'hAA; b8.en = 1'b1;
        arst = 1'b0;
        #1;
        checks++;
        if (b8.qdata !== 8'h01 || b8.dout !== 1'b1 || b8.lockup !== 1'b0 ||
            b8.period_valid !== 1'b0 || b8.period !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_async: q=%h lk=%b pv=%b per=%0d required q=01 lk=0 pv=0 per=0",
                     b8.qdata, b8.lockup, b8.period_valid, b8.period);
        end
        @(posedge clk); #1;
        checks++;
        if (b8.qdata !== 8'h01) begin
            errors++; $display("FAIL reset_mid_hold: q=%h required 01", b8.qdata);
        end
        @(negedge clk);
        idle_all();
        arst = 1'b1;
        mdl_reset();
        cyc8(0, 1, 2'b01, 0, 8'h00);
        checks++;
        if (b8.qdata !== 8'(m_q) || b8.period_valid !== 1'b0) begin
            errors++; $display("FAIL reset_first_edge: q=%h pv=%b required q=%h pv=0", b8.qdata, b8.period_valid, 8'(m_q));
        end
    endtask

    task automatic test_saturate();
        bit done = 0;
        set_cfg(8, 32'hB3, 1, 15);
        do_reset();
        for (int i = 0; i < 600 && !done; i++) begin
            cyc4(1, 2'b01);
            checks++;
            if (b4.qdata !== 8'(m_q) || b4.period_valid !== m_pv) begin
                errors++;
                $display("FAIL saturate cyc %0d: q=%h pv=%b required q=%h pv=%b",
                         i, b4.qdata, b4.period_valid, 8'(m_q), m_pv);
            end
            if (m_pv) done = 1;
        end
        checks++;
        if (!done || b4.period_valid !== 1'b1 || b4.period !== 4'(m_per)) begin
            errors++;
            $display("FAIL saturate_period: done=%b pv=%b per=%h required pv=1 per=%h",
                     done, b4.period_valid, b4.period, 4'(m_per));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_period3();
        test_random();
        test_en_toggle();
        test_load_priority();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
